sp3_uplink_link_ctrl: RTL
=========================

# sp3_uplink_link_ctrl

Link bring-up and health sequencer for the dual lpGBT uplink receiver on the shared SFP0 transceiver. Drives the shared MGT reset and the per-channel datapath resets, waits for both uplinks (A, B) to report ready, and then monitors ready loss and FEC-correction bursts. On a fault it re-sequences the link with bounded retries. Sits between the dual-RX core and the AXI register block. All inputs arrive already synchronous to S_AXI_ACLK.

## Interface
- TIMEOUT_CYCLES, 2000000: WAIT_RDY timeout, in clock cycles.
- RESET_PULSE, 64: length of each MGT and datapath reset pulse, in cycles; must be ≥1.
- MAX_RETRY, 8: consecutive failed attempts before FAIL; range 1–15.
- FEC_THRESH, 16: FEC events per window that constitute a fault; must be ≥1.
- FEC_WINDOW, 1000000: FEC observation window length, in cycles.
- S_AXI_ACLK  in  1  Sole clock.
- S_AXI_ARESETN  in  1  Asynchronous, active-low reset.
- enable_i  in  1  Level; 0 forces IDLE.
- force_reset_i  in  1  Single-cycle pulse; restarts the sequence.
- clear_cnt_i  in  1  Pulse; clears the FEC totals.
- uplinkrdy_a_i, uplinkrdy_b_i  in  1 each  Per-channel uplink ready.
- uplinkFEC_a_i, uplinkFEC_b_i  in  1 each  High for one cycle per corrected frame.
- mgt_reset_o  out  1  Shared transceiver reset, active-high.
- dp_reset_a_o, dp_reset_b_o  out  1 each  Datapath resets, active-high.
- link_up_a_o, link_up_b_o  out  1 each  Channel is up.
- fail_o  out  1  Retries exhausted.
- state_o  out  3  Current FSM state encoding.
- retry_cnt_o  out  4  Consecutive failed attempts.
- fec_total_a_o, fec_total_b_o  out  16 each  Saturating FEC event totals.

## Operation
- States and encodings: IDLE=0, MGT_RST=1, DP_RST=2, WAIT_RDY=3, LOCKED=4, FAIL=5.
- IDLE: mgt_reset_o=1 and both dp_reset=1. Moves to MGT_RST when enable_i=1; retry_cnt is cleared.
- MGT_RST: mgt_reset_o=1 and both dp_reset=1 for exactly RESET_PULSE cycles, then DP_RST.
- DP_RST: mgt_reset_o=0 and both dp_reset=1 for exactly RESET_PULSE cycles, then WAIT_RDY.
- WAIT_RDY: timer counts from 0.
  - Both rdy=1 in the same cycle → LOCKED; retry_cnt is cleared.
  - Timer reaches TIMEOUT_CYCLES-1 first → retry_cnt+1. If the new value equals MAX_RETRY, go to FAIL; otherwise go to MGT_RST.
  - If both events occur in the same cycle, LOCKED wins.
- LOCKED: link_up_x_o = uplinkrdy_x_i, registered.
  - Either rdy=0 → DP_RST, retry_cnt+1; a retry that reaches MAX_RETRY goes to FAIL instead.
  - FEC fault on either channel → DP_RST, with the same retry accounting.
- FAIL: all resets asserted, fail_o=1. Leaves only via enable_i=0 (to IDLE) or force_reset_i (to MGT_RST).
- Priority, highest first: reset, then enable_i=0 (IDLE from any state), then force_reset_i (MGT_RST from any non-IDLE state, retry_cnt cleared; ignored in IDLE), then the state's own transition rules.
- link_up_x_o is 0 in every state other than LOCKED.

## Timing
- All outputs are registered. State and output changes appear one clock after the qualifying input.
- Reset values: state=IDLE, mgt_reset_o=1, dp_reset_a_o=dp_reset_b_o=1, link_up=0, fail_o=0, retry_cnt=0, FEC totals=0.
- Minimum bring-up time: enable_i to LOCKED takes 2·RESET_PULSE+2 cycles when both rdy are already high.
- FEC window: starts on LOCKED entry and restarts every FEC_WINDOW cycles. The per-window count resets at each window start.
  - A fault fires in the cycle the count reaches FEC_THRESH; the state changes on the next clock.
- FEC totals: increment on every FEC pulse in any state and saturate at 0xFFFF.
  - clear_cnt_i zeroes the totals; if a pulse arrives in the same cycle, clear wins.

## Configuration
- SP3_UPLINK_FEC_MON_EN defined: FEC window monitoring and FEC totals are implemented as described above.
- SP3_UPLINK_FEC_MON_EN undefined:
  - uplinkFEC inputs are ignored and fec_total outputs are tied to 0.
  - LOCKED exits only on rdy loss, enable_i=0 or force_reset_i.

## Structure
- Package sp3_uplink_pkg: the state enum with its encodings, plus the counter-width localparams (retry 4 bits, totals 16 bits).
- Sub-module sp3_fec_window_mon: window counter, threshold compare and saturating total. Instantiated once per channel; omitted when SP3_UPLINK_FEC_MON_EN is undefined.

## Test plan
Bench parameters: RESET_PULSE=4, TIMEOUT_CYCLES=100, MAX_RETRY=2, FEC_THRESH=3, FEC_WINDOW=50.
- Clean bring-up: both rdy held high, enable_i raised → LOCKED after 10 cycles; link_up_a_o=link_up_b_o=1; retry_cnt_o=0.
- Timeout to FAIL: rdy_b held at 0 → two timeouts, retry_cnt_o reaches 2, FAIL with fail_o=1 and all resets=1. A force_reset_i pulse then returns the FSM to MGT_RST with retry_cnt_o=0.
- Rdy loss: in LOCKED, rdy_a drops for 1 cycle → DP_RST (mgt_reset_o stays 0), retry_cnt_o=1. Re-lock clears retry_cnt_o to 0.
- FEC fault: 3 FEC_a pulses within 50 cycles → DP_RST. 2 pulses in each of consecutive windows → no fault. fec_total_a_o is correct throughout.
- Saturation and clear: 70000 FEC_b pulses → fec_total_b_o=0xFFFF. clear_cnt_i coincident with a pulse → 0.
- Asynchronous reset asserted mid-WAIT_RDY → all outputs take their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/sp3_uplink_pkg.sv
// Shared types for the SFP0 dual lpGBT uplink link controller.
// Optional FEC monitoring is selected with SP3_UPLINK_FEC_MON_EN.
package sp3_uplink_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MGT_RST  = 3'd1,
    ST_DP_RST   = 3'd2,
    ST_WAIT_RDY = 3'd3,
    ST_LOCKED   = 3'd4,
    ST_FAIL     = 3'd5
  } state_e;

  localparam int RETRY_W = 4;
  localparam int TOT_W   = 16;

endpackage

// File: rtl/sp3_fec_window_mon.sv
// Per-channel FEC window counter, threshold fault and saturating total.
// Only instantiated when SP3_UPLINK_FEC_MON_EN is defined.
module sp3_fec_window_mon
  import sp3_uplink_pkg::*;
#(
  parameter int FEC_THRESH = 16,
  parameter int FEC_WINDOW = 1000000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             active_i,
  input  logic             fec_i,
  input  logic             clear_i,
  output logic             fault_o,
  output logic [TOT_W-1:0] total_o
);

  localparam int WIN_W = (FEC_WINDOW > 1) ? $clog2(FEC_WINDOW) : 1;
  localparam int CNT_W = $clog2(FEC_THRESH + 1);

  logic [WIN_W-1:0] win_q;
  logic [CNT_W-1:0] cnt_q;
  logic [TOT_W-1:0] total_q;
  logic             win_last;

  assign win_last = (win_q == WIN_W'(FEC_WINDOW - 1));
  // The pulse that brings the count to threshold raises the fault.
  assign fault_o  = active_i & fec_i &
                    (cnt_q == CNT_W'(FEC_THRESH - 1));
  assign total_o  = total_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      win_q   <= '0;
      cnt_q   <= '0;
      total_q <= '0;
    end else begin
      if (!active_i || win_last) begin
        win_q <= '0;
        cnt_q <= '0;
      end else begin
        win_q <= win_q + 1'b1;
        if (fec_i) cnt_q <= cnt_q + 1'b1;
      end
      if (clear_i) begin
        total_q <= '0;
      end else if (fec_i && (total_q != '1)) begin
        total_q <= total_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sp3_uplink_link_ctrl.sv
// Bring-up and health sequencer for the shared SFP0 dual uplink.
// Define SP3_UPLINK_FEC_MON_EN to enable FEC window monitoring.
module sp3_uplink_link_ctrl
  import sp3_uplink_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int RESET_PULSE    = 64,
  parameter int MAX_RETRY      = 8,
  parameter int FEC_THRESH     = 16,
  parameter int FEC_WINDOW     = 1000000
) (
  input  logic               S_AXI_ACLK,
  input  logic               S_AXI_ARESETN,
  input  logic               enable_i,
  input  logic               force_reset_i,
  input  logic               clear_cnt_i,
  input  logic               uplinkrdy_a_i,
  input  logic               uplinkrdy_b_i,
  input  logic               uplinkFEC_a_i,
  input  logic               uplinkFEC_b_i,
  output logic               mgt_reset_o,
  output logic               dp_reset_a_o,
  output logic               dp_reset_b_o,
  output logic               link_up_a_o,
  output logic               link_up_b_o,
  output logic               fail_o,
  output logic [2:0]         state_o,
  output logic [RETRY_W-1:0] retry_cnt_o,
  output logic [TOT_W-1:0]   fec_total_a_o,
  output logic [TOT_W-1:0]   fec_total_b_o
);

  localparam int TMAX  = (TIMEOUT_CYCLES > RESET_PULSE) ?
                         TIMEOUT_CYCLES : RESET_PULSE;
  localparam int TMR_W = $clog2(TMAX) + 1;

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [RETRY_W-1:0] retry_q, retry_d, retry_inc;
  logic               mgt_q, dpa_q, dpb_q;
  logic               lua_q, lub_q, fail_q;
  logic               restart, rp_done, to_done;
  logic               both_rdy, fec_fault;

`ifdef SP3_UPLINK_FEC_MON_EN
  logic fault_a, fault_b;
  logic locked;

  assign locked    = (state_q == ST_LOCKED);
  assign fec_fault = fault_a | fault_b;

  sp3_fec_window_mon #(
    .FEC_THRESH (FEC_THRESH),
    .FEC_WINDOW (FEC_WINDOW)
  ) u_mon_a (
    .clk_i    (S_AXI_ACLK),
    .rst_ni   (S_AXI_ARESETN),
    .active_i (locked),
    .fec_i    (uplinkFEC_a_i),
    .clear_i  (clear_cnt_i),
    .fault_o  (fault_a),
    .total_o  (fec_total_a_o)
  );

  sp3_fec_window_mon #(
    .FEC_THRESH (FEC_THRESH),
    .FEC_WINDOW (FEC_WINDOW)
  ) u_mon_b (
    .clk_i    (S_AXI_ACLK),
    .rst_ni   (S_AXI_ARESETN),
    .active_i (locked),
    .fec_i    (uplinkFEC_b_i),
    .clear_i  (clear_cnt_i),
    .fault_o  (fault_b),
    .total_o  (fec_total_b_o)
  );
`else
  logic unused_fec;

  assign unused_fec    = ^{uplinkFEC_a_i, uplinkFEC_b_i, clear_cnt_i,
                           FEC_THRESH[0], FEC_WINDOW[0]};
  assign fec_fault     = 1'b0;
  assign fec_total_a_o = '0;
  assign fec_total_b_o = '0;
`endif

  assign both_rdy  = uplinkrdy_a_i & uplinkrdy_b_i;
  assign rp_done   = (timer_q == TMR_W'(RESET_PULSE - 1));
  assign to_done   = (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));
  assign retry_inc = retry_q + 1'b1;

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    restart = 1'b0;
    if (!enable_i) begin
      state_d = ST_IDLE;
    end else if (force_reset_i && (state_q != ST_IDLE)) begin
      state_d = ST_MGT_RST;
      retry_d = '0;
      restart = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_MGT_RST;
          retry_d = '0;
        end
        ST_MGT_RST: if (rp_done) state_d = ST_DP_RST;
        ST_DP_RST:  if (rp_done) state_d = ST_WAIT_RDY;
        ST_WAIT_RDY: begin
          // Lock wins over a coincident timeout.
          if (both_rdy) begin
            state_d = ST_LOCKED;
            retry_d = '0;
          end else if (to_done) begin
            retry_d = retry_inc;
            state_d = (retry_inc == RETRY_W'(MAX_RETRY)) ?
                      ST_FAIL : ST_MGT_RST;
          end
        end
        ST_LOCKED: begin
          if (!both_rdy || fec_fault) begin
            retry_d = retry_inc;
            state_d = (retry_inc == RETRY_W'(MAX_RETRY)) ?
                      ST_FAIL : ST_DP_RST;
          end
        end
        ST_FAIL: state_d = ST_FAIL;
        default: state_d = ST_IDLE;
      endcase
    end
    timer_d = (restart || (state_d != state_q)) ?
              '0 : timer_q + 1'b1;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      retry_q <= '0;
      mgt_q   <= 1'b1;
      dpa_q   <= 1'b1;
      dpb_q   <= 1'b1;
      lua_q   <= 1'b0;
      lub_q   <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      retry_q <= retry_d;
      mgt_q   <= (state_d == ST_IDLE) || (state_d == ST_MGT_RST) ||
                 (state_d == ST_FAIL);
      dpa_q   <= (state_d != ST_WAIT_RDY) && (state_d != ST_LOCKED);
      dpb_q   <= (state_d != ST_WAIT_RDY) && (state_d != ST_LOCKED);
      lua_q   <= (state_d == ST_LOCKED) && uplinkrdy_a_i;
      lub_q   <= (state_d == ST_LOCKED) && uplinkrdy_b_i;
      fail_q  <= (state_d == ST_FAIL);
    end
  end

  assign state_o      = state_q;
  assign retry_cnt_o  = retry_q;
  assign mgt_reset_o  = mgt_q;
  assign dp_reset_a_o = dpa_q;
  assign dp_reset_b_o = dpb_q;
  assign link_up_a_o  = lua_q;
  assign link_up_b_o  = lub_q;
  assign fail_o       = fail_q;

endmodule
